// File: rtl/mult_seq_core.sv
// Sequential unsigned DW x DW multiplier: four half-width partial products over four cycles,
// driving a downstream output register. Optional MULT_SEQ_ERR_EN adds a sticky start-while-busy err.
module mult_seq_core #(
    parameter int unsigned DW = 8
) (
    input  logic            clk,
    input  logic            sclr,
    input  logic            start,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [2*DW-1:0] product_out,
    output logic            busy,
    output logic            done,
    output logic            reg_clk_ena,
    output logic            reg_sclr_n
`ifdef MULT_SEQ_ERR_EN
    ,
    output logic            err
`endif
);

    localparam int unsigned HW  = DW / 2;
    localparam int unsigned PPW = 2 * HW;
    localparam int unsigned PW  = 2 * DW;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LSB   = 3'd1,
        MID_A = 3'd2,
        MID_B = 3'd3,
        MSB   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t          state, state_next;
    logic [DW-1:0]   a_q, b_q, a_next, b_next;
    logic [PW-1:0]   acc, acc_next;
    logic [HW-1:0]   op_a, op_b;
    logic [PPW-1:0]  pp;
    logic [PW-1:0]   pp_shifted;

    // One shared half-width multiplier; operand halves and shift are selected by state
    always_comb begin
        op_a       = a_q[HW-1:0];
        op_b       = b_q[HW-1:0];
        if (state == MID_A || state == MSB) op_a = a_q[DW-1:HW];
        if (state == MID_B || state == MSB) op_b = b_q[DW-1:HW];
        pp         = PPW'(op_a) * PPW'(op_b);
        pp_shifted = PW'(pp);
        case (state)
            MID_A, MID_B: pp_shifted = PW'(pp) << HW;
            MSB:          pp_shifted = PW'(pp) << DW;
            default:      pp_shifted = PW'(pp);
        endcase
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        a_next     = a_q;
        b_next     = b_q;
        case (state)
            IDLE: begin
                if (start) begin
                    a_next     = a;
                    b_next     = b;
                    acc_next   = '0;
                    state_next = LSB;
                end
            end
            LSB: begin
                acc_next   = pp_shifted;
                state_next = MID_A;
            end
            MID_A: begin
                acc_next   = acc + pp_shifted;
                state_next = MID_B;
            end
            MID_B: begin
                acc_next   = acc + pp_shifted;
                state_next = MSB;
            end
            MSB: begin
                acc_next   = acc + pp_shifted;
                state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // busy/done are registered copies of the next state so they track state without decode glitches
    always_ff @(posedge clk) begin
        if (sclr) begin
            state <= IDLE;
            acc   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            a_q   <= a_next;
            b_q   <= b_next;
            busy  <= (state_next != IDLE);
            done  <= (state_next == DONE);
        end
    end

`ifdef MULT_SEQ_ERR_EN
    always_ff @(posedge clk) begin
        if (sclr) begin
            err <= 1'b0;
        end else if (start && busy) begin
            err <= 1'b1;
        end
    end
`endif

    // Downstream register loads the final product once, or clears alongside our reset
    assign product_out = acc;
    assign reg_clk_ena = sclr | done;
    assign reg_sclr_n  = ~sclr;

endmodule
